time_keeper: RTL and testbench

Time-of-day counter for the clock design, downstream of the seconds/milliseconds clock synchronizer. It consumes the `changeSec` level and counts one second on each of its rising edges. The level rises on the seconds clock and is cleared on the milliseconds clock, so this block treats it as asynchronous. It keeps hh:mm:ss in BCD digits for the display stage and supports a manual set mode for each field.

---
 rtl/time_keeper.sv | 142 ++++++++++++++
 tb/tb_time_keeper.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/time_keeper.sv
// time_keeper: hh:mm:ss BCD time-of-day counter with a manual set mode.
// Ports: clkMSec/resetN clock and async reset. changeSec is the async seconds level.
//        setEn/setField/setInc drive set mode. The six BCD digits give the time.
//        tick and rollover are one-cycle status pulses.
module time_keeper #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clkMSec,
   input  logic       resetN,
   input  logic       changeSec,
   input  logic       setEn,
   input  logic [1:0] setField,
   input  logic       setInc,
   output logic [3:0] secOnes,
   output logic [2:0] secTens,
   output logic [3:0] minOnes,
   output logic [2:0] minTens,
   output logic [3:0] hrOnes,
   output logic [1:0] hrTens,
   output logic       tick,
   output logic       rollover
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   inc_q;

   logic [3:0] secO_q, secO_d;
   logic [2:0] secT_q, secT_d;
   logic [3:0] minO_q, minO_d;
   logic [2:0] minT_q, minT_d;
   logic [3:0] hrO_q, hrO_d;
   logic [1:0] hrT_q, hrT_d;
   logic       tick_q, tick_d;
   logic       roll_q, roll_d;

   logic secEdge, incEdge;
   logic secWrap, minWrap, hrWrap;

   // 00..59 field increment, wrapping within the field
   function automatic logic [6:0] inc60(input logic [2:0] t,
                                        input logic [3:0] o);
      if (o == 4'd9) begin
         if (t == 3'd5) return 7'd0;
         return {t + 3'd1, 4'd0};
      end
      return {t, o + 4'd1};
   endfunction

   // 00..23 field increment, wrapping within the field
   function automatic logic [5:0] inc24(input logic [1:0] t,
                                        input logic [3:0] o);
      if (t == 2'd2 && o == 4'd3) return 6'd0;
      if (o == 4'd9) return {t + 2'd1, 4'd0};
      return {t, o + 4'd1};
   endfunction

   // Synchronizer and history flops reset high so a level already
   // high at reset release is never seen as a rising edge.
   always_ff @(posedge clkMSec or negedge resetN) begin
      if (!resetN) begin
         sync_q <= '1;
         hist_q <= 1'b1;
         inc_q  <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], changeSec};
         hist_q <= sync_q[SYNC_STAGES-1];
         inc_q  <= setInc;
      end
   end

   assign secEdge = sync_q[SYNC_STAGES-1] & ~hist_q;
   assign incEdge = setInc & ~inc_q;

   assign secWrap = (secT_q == 3'd5) && (secO_q == 4'd9);
   assign minWrap = (minT_q == 3'd5) && (minO_q == 4'd9);
   assign hrWrap  = (hrT_q == 2'd2) && (hrO_q == 4'd3);

   always_comb begin
      secO_d = secO_q;
      secT_d = secT_q;
      minO_d = minO_q;
      minT_d = minT_q;
      hrO_d  = hrO_q;
      hrT_d  = hrT_q;
      tick_d = 1'b0;
      roll_d = 1'b0;
      if (setEn) begin
         // set mode swallows secEdge; only the selected field moves
         if (incEdge) begin
            unique case (setField)
               2'd0: {secT_d, secO_d} = inc60(secT_q, secO_q);
               2'd1: {minT_d, minO_d} = inc60(minT_q, minO_q);
               2'd2: {hrT_d, hrO_d}   = inc24(hrT_q, hrO_q);
               default: ;
            endcase
         end
      end else if (secEdge) begin
         tick_d = 1'b1;
         {secT_d, secO_d} = inc60(secT_q, secO_q);
         if (secWrap) begin
            {minT_d, minO_d} = inc60(minT_q, minO_q);
            if (minWrap) begin
               {hrT_d, hrO_d} = inc24(hrT_q, hrO_q);
               roll_d = hrWrap;
            end
         end
      end
   end

   always_ff @(posedge clkMSec or negedge resetN) begin
      if (!resetN) begin
         secO_q <= '0;
         secT_q <= '0;
         minO_q <= '0;
         minT_q <= '0;
         hrO_q  <= '0;
         hrT_q  <= '0;
         tick_q <= 1'b0;
         roll_q <= 1'b0;
      end else begin
         secO_q <= secO_d;
         secT_q <= secT_d;
         minO_q <= minO_d;
         minT_q <= minT_d;
         hrO_q  <= hrO_d;
         hrT_q  <= hrT_d;
         tick_q <= tick_d;
         roll_q <= roll_d;
      end
   end

   assign secOnes  = secO_q;
   assign secTens  = secT_q;
   assign minOnes  = minO_q;
   assign minTens  = minT_q;
   assign hrOnes   = hrO_q;
   assign hrTens   = hrT_q;
   assign tick     = tick_q;
   assign rollover = roll_q;

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed + random bench for time_keeper.
// Reference model holds time as a plain seconds-of-day integer.
module tb_time_keeper;

   localparam int SS = 2;

   logic       clk = 1'b0;
   logic       resetN;
   logic       changeSec;
   logic       setEn;
   logic [1:0] setField;
   logic       setInc;
   logic [3:0] secOnes, minOnes, hrOnes;
   logic [2:0] secTens, minTens;
   logic [1:0] hrTens;
   logic       tick, rollover;

   time_keeper #(.SYNC_STAGES(SS)) dut (
      .clkMSec(clk),
      .resetN(resetN),
      .changeSec(changeSec),
      .setEn(setEn),
      .setField(setField),
      .setInc(setInc),
      .secOnes(secOnes),
      .secTens(secTens),
      .minOnes(minOnes),
      .minTens(minTens),
      .hrOnes(hrOnes),
      .hrTens(hrTens),
      .tick(tick),
      .rollover(rollover)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int tick_seen = 0;
   int secs = 0;
   int t0;

   always @(negedge clk) if (tick === 1'b1) tick_seen++;

   wire [19:0] cur = {hrTens, hrOnes, minTens, minOnes, secTens, secOnes};

   function automatic logic [19:0] bcd(input int t);
      int h, m, s;
      h = t / 3600;
      m = (t / 60) % 60;
      s = t % 60;
      return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10),
              3'(s / 10), 4'(s % 10)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // one changeSec pulse; counts says whether the model should advance
   task automatic pulse_sec(input bit counts, input int hi, input int lo);
      bit wrap;
      changeSec = 1'b1;
      step();
      repeat (SS - 1) step();
      chk("pre_tick", 32'(tick), 0);
      chk("pre_time", 32'(cur), 32'(bcd(secs)));
      step();
      wrap = (secs == 86399);
      if (counts) secs = (secs + 1) % 86400;
      chk("tick", 32'(tick), 32'(counts));
      chk("roll", 32'(rollover), 32'(counts && wrap));
      chk("time", 32'(cur), 32'(bcd(secs)));
      step();
      chk("tick_end", 32'(tick), 0);
      chk("roll_end", 32'(rollover), 0);
      repeat (hi) step();
      changeSec = 1'b0;
      repeat (lo) step();
   endtask

   task automatic model_inc(input int f);
      int h, m, s;
      h = secs / 3600;
      m = (secs / 60) % 60;
      s = secs % 60;
      case (f)
         0: s = (s + 1) % 60;
         1: m = (m + 1) % 60;
         2: h = (h + 1) % 24;
         default: ;
      endcase
      secs = h * 3600 + m * 60 + s;
   endtask

   // caller holds setEn high
   task automatic set_inc(input int f, input bit check);
      setField = 2'(f);
      setInc = 1'b1;
      step();
      model_inc(f);
      if (check) begin
         chk("set_time", 32'(cur), 32'(bcd(secs)));
         chk("set_tick", 32'(tick), 0);
         chk("set_roll", 32'(rollover), 0);
      end
      setInc = 1'b0;
      step();
   endtask

   task automatic set_to(input int h, input int m, input int s);
      setEn = 1'b1;
      step();
      while ((secs / 3600) != h) set_inc(2, 0);
      while (((secs / 60) % 60) != m) set_inc(1, 0);
      while ((secs % 60) != s) set_inc(0, 0);
      chk("set_to", 32'(cur), 32'(bcd(secs)));
      setEn = 1'b0;
      step();
   endtask

   initial begin
      resetN = 1'b0;
      changeSec = 1'b0;
      setEn = 1'b0;
      setField = 2'd0;
      setInc = 1'b0;
      #7;
      chk("rst_time", 32'(cur), 0);
      chk("rst_tick", 32'(tick), 0);
      chk("rst_roll", 32'(rollover), 0);
      step();
      resetN = 1'b1;
      repeat (3) step();

      // ten seconds, 20 cycles apart
      t0 = tick_seen;
      for (int i = 0; i < 10; i++) pulse_sec(1, 1, 15);
      chk("ten_time", 32'(cur), 32'(bcd(10)));
      chk("ten_ticks", 32'(tick_seen - t0), 10);

      // midnight wrap
      set_to(23, 59, 58);
      pulse_sec(1, 2, 6);
      chk("t_235959", 32'(cur), 32'(bcd(86399)));
      t0 = tick_seen;
      pulse_sec(1, 2, 6);
      chk("t_000000", 32'(cur), 0);
      chk("wrap_ticks", 32'(tick_seen - t0), 1);

      // minute wrap in set mode leaves hours alone
      set_to(7, 59, 30);
      setEn = 1'b1;
      step();
      set_inc(1, 1);
      chk("min_wrap", 32'(cur), 32'(bcd(7 * 3600 + 30)));
      setField = 2'd1;
      setInc = 1'b1;
      step();
      model_inc(1);
      chk("hold_first", 32'(cur), 32'(bcd(secs)));
      repeat (49) step();
      setInc = 1'b0;
      step();
      chk("hold_once", 32'(cur), 32'(bcd(secs)));
      set_inc(3, 1);
      chk("field3", 32'(cur), 32'(bcd(7 * 3600 + 60 + 30)));

      // seconds discarded in set mode; exit while level still high
      t0 = tick_seen;
      for (int i = 0; i < 5; i++) pulse_sec(0, 1, 5);
      changeSec = 1'b1;
      repeat (SS + 3) step();
      setEn = 1'b0;
      repeat (6) step();
      chk("exit_time", 32'(cur), 32'(bcd(secs)));
      chk("exit_ticks", 32'(tick_seen - t0), 0);
      changeSec = 1'b0;
      repeat (5) step();
      pulse_sec(1, 1, 5);

      // level held high through reset release
      changeSec = 1'b1;
      resetN = 1'b0;
      secs = 0;
      repeat (2) step();
      resetN = 1'b1;
      t0 = tick_seen;
      repeat (8) step();
      chk("held_time", 32'(cur), 0);
      chk("held_ticks", 32'(tick_seen - t0), 0);
      changeSec = 1'b0;
      repeat (5) step();
      pulse_sec(1, 1, 5);
      chk("held_next", 32'(cur), 32'(bcd(1)));

      // random mix
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 2))
            0: pulse_sec(1, $urandom_range(0, 4), $urandom_range(4, 10));
            1: begin
               setEn = 1'b1;
               step();
               repeat ($urandom_range(1, 4)) set_inc($urandom_range(0, 3), 1);
               setEn = 1'b0;
               step();
            end
            default: begin
               setEn = 1'b1;
               step();
               pulse_sec(0, $urandom_range(0, 3), $urandom_range(4, 8));
               setEn = 1'b0;
               step();
            end
         endcase
      end
      chk("rand_time", 32'(cur), 32'(bcd(secs)));

      // asynchronous reset between edges
      set_to(12, 34, 56);
      chk("pre_rst", 32'(cur), 32'(bcd(45296)));
      @(posedge clk);
      #3;
      resetN = 1'b0;
      #1;
      chk("async_time", 32'(cur), 0);
      chk("async_tick", 32'(tick), 0);
      chk("async_roll", 32'(rollover), 0);
      step();
      resetN = 1'b1;
      step();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule
